// File: rtl/fc_layer_sequencer.sv
// rtl/fc_layer_sequencer.sv - time-multiplexes one FC engine across the LeNet-5 FC1/FC2/FC3 layers
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             begin a sequence (accepted only in IDLE or ERR)
//   abort             abandon the sequence, highest priority after rst
//   engine_done       FC engine done level, only honoured in RUN
//   engine_en         FC engine enable; low returns the engine to its idle state
//   cfg_in_map        input length of the current layer
//   cfg_out_map       output length of the current layer
//   cfg_wbase         weight-memory word base of the current layer
//   cfg_relu_en       apply ReLU on the bias-add pass
//   buf_sel           ping-pong activation buffer (engine reads buf_sel, writes ~buf_sel)
//   layer             current layer index
//   busy              sequencer not idle
//   done              one-cycle pulse when all layers have finished
//   err               sticky per-layer timeout flag
//   perf_cycles       engine-enabled cycle count of the last sequence
//
// Build option: FC_SEQ_PERF_CNT_EN enables the perf_cycles counter; when it is
// undefined perf_cycles is tied to zero.

module fc_layer_sequencer #(
    parameter int NUM_LAYERS   = 3,
    parameter int READ_SET     = 16,
    parameter int DRAIN_CYCLES = 2,
    parameter int TIMEOUT      = 200000,
    parameter int TO_WIDTH     = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        engine_done,
    output logic        engine_en,
    output logic [8:0]  cfg_in_map,
    output logic [6:0]  cfg_out_map,
    output logic [11:0] cfg_wbase,
    output logic        cfg_relu_en,
    output logic        buf_sel,
    output logic [1:0]  layer,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] perf_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    // Weight bases: each layer's weights start right after the previous
    // layer's in*out weights, packed READ_SET per memory word.
    localparam int WB1 = (400 * 120 + READ_SET - 1) / READ_SET;
    localparam int WB2 = WB1 + (120 * 84 + READ_SET - 1) / READ_SET;

    localparam logic [TO_WIDTH-1:0] TO_LAST    = TO_WIDTH'(TIMEOUT - 1);
    localparam logic [7:0]          DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
    localparam logic [1:0]          LAST_LAYER = 2'(NUM_LAYERS - 1);

    state_t              state;
    logic [TO_WIDTH-1:0] to_cnt;
    logic [7:0]          drain_cnt;

    // Packed {in_map, out_map, wbase, relu_en} for one layer.
    function automatic logic [28:0] layer_cfg(input logic [1:0] idx);
        case (idx)
            2'd0:    return {9'd400, 7'd120, 12'd0,       1'b1};
            2'd1:    return {9'd120, 7'd84,  12'(WB1),    1'b1};
            default: return {9'd84,  7'd10,  12'(WB2),    1'b0};
        endcase
    endfunction

    // cfg_* are loaded on the same edge that layer changes so they are stable
    // for the whole CFG/RUN/DRAIN span without a lagging pipeline stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            layer       <= 2'd0;
            {cfg_in_map, cfg_out_map, cfg_wbase, cfg_relu_en} <= layer_cfg(2'd0);
            engine_en   <= 1'b0;
            buf_sel     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            to_cnt      <= '0;
            drain_cnt   <= '0;
        end else if (abort) begin
            // Same as reset except err is preserved for the controller.
            state       <= S_IDLE;
            layer       <= 2'd0;
            {cfg_in_map, cfg_out_map, cfg_wbase, cfg_relu_en} <= layer_cfg(2'd0);
            engine_en   <= 1'b0;
            buf_sel     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            to_cnt      <= '0;
            drain_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_CFG;
                        busy    <= 1'b1;
                        layer   <= 2'd0;
                        {cfg_in_map, cfg_out_map, cfg_wbase, cfg_relu_en} <= layer_cfg(2'd0);
                        buf_sel <= 1'b0;
                    end
                end

                S_CFG: begin
                    state     <= S_RUN;
                    engine_en <= 1'b1;
                    to_cnt    <= '0;
                end

                S_RUN: begin
                    // engine_done is checked first so a done on the final
                    // timeout cycle still completes the layer.
                    if (engine_done) begin
                        state     <= S_DRAIN;
                        engine_en <= 1'b0;
                        drain_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        state     <= S_ERR;
                        engine_en <= 1'b0;
                        err       <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        buf_sel <= ~buf_sel;
                        if (layer == LAST_LAYER) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_CFG;
                            layer <= layer + 2'd1;
                            {cfg_in_map, cfg_out_map, cfg_wbase, cfg_relu_en} <= layer_cfg(layer + 2'd1);
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    // layer stays at the last index until the next start.
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                S_ERR: begin
                    if (start) begin
                        state   <= S_CFG;
                        err     <= 1'b0;
                        layer   <= 2'd0;
                        {cfg_in_map, cfg_out_map, cfg_wbase, cfg_relu_en} <= layer_cfg(2'd0);
                        buf_sel <= 1'b0;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    engine_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef FC_SEQ_PERF_CNT_EN
    logic start_seq;

    assign start_seq = start && ((state == S_IDLE) || (state == S_ERR));

    // Counts cycles with engine_en high; cleared on sequence start and simply
    // stops advancing once engine_en stays low (done, error, abort).
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (!abort && start_seq) begin
            perf_cycles <= '0;
        end else if (engine_en) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb/tb_fc_layer_sequencer.sv - self-checking bench for fc_layer_sequencer
module tb_fc_layer_sequencer;

    localparam int TO = 100;
    localparam int DR = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        engine_done = 1'b0;
    logic        engine_en;
    logic [8:0]  cfg_in_map;
    logic [6:0]  cfg_out_map;
    logic [11:0] cfg_wbase;
    logic        cfg_relu_en;
    logic        buf_sel;
    logic [1:0]  layer;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] perf_cycles;

    always #5 clk = ~clk;

    fc_layer_sequencer #(
        .NUM_LAYERS(3), .READ_SET(16), .DRAIN_CYCLES(DR), .TIMEOUT(TO), .TO_WIDTH(20)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .engine_done(engine_done),
        .engine_en(engine_en), .cfg_in_map(cfg_in_map), .cfg_out_map(cfg_out_map),
        .cfg_wbase(cfg_wbase), .cfg_relu_en(cfg_relu_en), .buf_sel(buf_sel),
        .layer(layer), .busy(busy), .done(done), .err(err), .perf_cycles(perf_cycles)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Layer table from the network shape; weight bases by ceil(in*out/16).
    int in_t[3]   = '{400, 120, 84};
    int out_t[3]  = '{120, 84, 10};
    int relu_t[3] = '{1, 1, 0};
    int wb_t[3];
    initial begin
        wb_t[0] = 0;
        for (int k = 0; k < 2; k++) wb_t[k+1] = wb_t[k] + (in_t[k] * out_t[k] + 15) / 16;
    end

    // Engine model: done rises eng_t[layer] cycles after engine_en rises and
    // stays high while enabled; 'spurious' forces done high whenever disabled.
    int eng_t[3] = '{50, 50, 50};
    int en_cnt = 0;
    bit spurious = 1'b0;
    always @(negedge clk) begin
        if (engine_en === 1'b1) begin
            en_cnt++;
            engine_done = (en_cnt > eng_t[int'(layer)]);
        end else begin
            en_cnt = 0;
            engine_done = spurious;
        end
    end

    // Scoreboard state
    int exp_perf = 0;
    int run_idx  = -1;
    int cur_len  = 0;
    int gap_len  = 0;
    int done_cnt = 0;
    bit prev_en = 1'b0;
    bit prev_done = 1'b0;
    bit start_acc = 1'b0;
    int win_q[$];
    int gap_q[$];

    always @(posedge clk) begin
        #1;
        if (rst) begin
            exp_perf = 0;
        end else if (start_acc) begin
            exp_perf  = 0;
            run_idx   = -1;
            gap_len   = 0;
            start_acc = 1'b0;
        end else if (prev_en) begin
            exp_perf++;
        end
`ifdef FC_SEQ_PERF_CNT_EN
        chk("perf_track", perf_cycles, exp_perf);
`else
        chk("perf_zero", perf_cycles, 0);
`endif
        if (engine_en && !prev_en) begin
            if (run_idx >= 0) gap_q.push_back(gap_len);
            run_idx++;
            cur_len = 0;
            gap_len = 0;
        end
        if (!engine_en && prev_en) win_q.push_back(cur_len);
        if (engine_en) begin
            cur_len++;
            chk("run_layer", layer, run_idx);
            if (run_idx >= 0 && run_idx < 3) begin
                chk("run_in_map", cfg_in_map, in_t[run_idx]);
                chk("run_out_map", cfg_out_map, out_t[run_idx]);
                chk("run_wbase", cfg_wbase, wb_t[run_idx]);
                chk("run_relu", cfg_relu_en, relu_t[run_idx]);
                chk("run_buf_sel", buf_sel, run_idx % 2);
            end
        end else begin
            gap_len++;
        end
        if (done) begin
            done_cnt++;
            chk("done_width", prev_done, 0);
            chk("done_layer", layer, 2);
            chk("done_buf_sel", buf_sel, 1);
            chk("done_en", engine_en, 0);
        end
        prev_en   = engine_en;
        prev_done = done;
    end

    // Driver helpers
    task automatic do_start(input bit accept);
        @(negedge clk);
        start = 1'b1;
        if (accept) start_acc = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_en(input logic v, input int budget);
        int n = 0;
        while (engine_en !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_en", engine_en, v);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic wait_err(input int budget);
        int n = 0;
        while (err !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("err_seen", err, 1);
    endtask

    task automatic clear_q();
        win_q.delete();
        gap_q.delete();
    endtask

    task automatic check_windows(input int n, input int len);
        chk("win_count", win_q.size(), n);
        foreach (win_q[i]) chk("win_len", win_q[i], len);
    endtask

    task automatic check_perf(input int v);
`ifdef FC_SEQ_PERF_CNT_EN
        chk("perf_total", perf_cycles, v);
`else
        chk("perf_total_zero", perf_cycles, 0);
        if (v < 0) $display("unexpected perf argument");
`endif
    endtask

    task automatic check_cfg(input string tag, input int i, input int o, input int w, input int r);
        chk({tag, "_in"}, cfg_in_map, i);
        chk({tag, "_out"}, cfg_out_map, o);
        chk({tag, "_wbase"}, cfg_wbase, w);
        chk({tag, "_relu"}, cfg_relu_en, r);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_en"}, engine_en, 0);
        chk({tag, "_layer"}, layer, 0);
        chk({tag, "_buf_sel"}, buf_sel, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_perf"}, perf_cycles, 0);
        check_cfg(tag, 400, 120, 0, 1);
    endtask

    initial begin
        #(10 * 50000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int d0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal three-layer run
        eng_t = '{50, 50, 50};
        clear_q();
        d0 = done_cnt;
        do_start(1);
        chk("lat_cfg_en", engine_en, 0);
        chk("lat_cfg_busy", busy, 1);
        @(negedge clk);
        chk("lat_first_en", engine_en, 1);
        check_cfg("nom_l0", 400, 120, 0, 1);
        chk("nom_l0_buf", buf_sel, 0);
        wait_en(0, 200);
        wait_en(1, 20);
        check_cfg("nom_l1", 120, 84, 3000, 1);
        chk("nom_l1_buf", buf_sel, 1);
        wait_en(0, 200);
        wait_en(1, 20);
        check_cfg("nom_l2", 84, 10, 3630, 0);
        chk("nom_l2_buf", buf_sel, 0);
        wait_done(200);
        chk("nom_done_buf", buf_sel, 1);
        chk("nom_done_busy", busy, 1);
        @(negedge clk);
        chk("nom_busy_fall", busy, 0);
        chk("nom_done_low", done, 0);
        chk("nom_done_cnt", done_cnt - d0, 1);
        check_windows(3, 51);
        chk("nom_gap_count", gap_q.size(), 2);
        foreach (gap_q[i]) chk("nom_gap_len", gap_q[i], DR + 1);
        check_perf(153);

        // Timeout in L1, then restart from ERR
        eng_t = '{50, 100000, 50};
        clear_q();
        d0 = done_cnt;
        do_start(1);
        wait_err(500);
        chk("to_en", engine_en, 0);
        chk("to_layer", layer, 1);
        chk("to_busy", busy, 1);
        chk("to_win_count", win_q.size(), 2);
        if (win_q.size() == 2) begin
            chk("to_win_l0", win_q[0], 51);
            chk("to_win_l1", win_q[1], TO);
        end
        check_perf(151);
        repeat (5) @(negedge clk);
        chk("to_err_held", err, 1);
        chk("to_en_held", engine_en, 0);
        chk("to_no_done", done_cnt - d0, 0);
        eng_t = '{50, 50, 50};
        clear_q();
        do_start(1);
        chk("restart_err", err, 0);
        chk("restart_layer", layer, 0);
        chk("restart_buf", buf_sel, 0);
        chk("restart_busy", busy, 1);
        wait_done(400);
        check_windows(3, 51);
        check_perf(153);

        // Abort in RUN of L1
        clear_q();
        d0 = done_cnt;
        do_start(1);
        wait_en(1, 20);
        wait_en(0, 200);
        wait_en(1, 20);
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_en", engine_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_layer", layer, 0);
        chk("abort_buf", buf_sel, 0);
        chk("abort_err", err, 0);
        chk("abort_in_map", cfg_in_map, 400);
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_idle", busy, 0);
        clear_q();
        do_start(1);
        wait_done(400);
        chk("abort_rerun_done", done_cnt - d0, 1);
        check_windows(3, 51);
        check_perf(153);

        // Spurious engine_done outside RUN and start during RUN
        spurious = 1'b1;
        repeat (4) @(negedge clk);
        chk("spur_idle_busy", busy, 0);
        chk("spur_idle_en", engine_en, 0);
        chk("spur_idle_layer", layer, 2);
        clear_q();
        d0 = done_cnt;
        do_start(1);
        @(negedge clk);
        chk("spur_cfg_to_run", engine_en, 1);
        repeat (20) @(negedge clk);
        do_start(0);
        chk("spur_start_en", engine_en, 1);
        chk("spur_start_layer", layer, 0);
        wait_done(400);
        chk("spur_done_cnt", done_cnt - d0, 1);
        check_windows(3, 51);
        chk("spur_gap_count", gap_q.size(), 2);
        foreach (gap_q[i]) chk("spur_gap_len", gap_q[i], DR + 1);
        check_perf(153);
        spurious = 1'b0;

        // engine_done rises on the last timeout cycle
        eng_t = '{TO - 1, TO - 1, TO - 1};
        clear_q();
        d0 = done_cnt;
        do_start(1);
        wait_done(600);
        chk("coin_err", err, 0);
        chk("coin_done_cnt", done_cnt - d0, 1);
        check_windows(3, TO);
        check_perf(3 * TO);

        // Reset mid-DRAIN of L0
        eng_t = '{50, 50, 50};
        clear_q();
        do_start(1);
        wait_en(1, 20);
        wait_en(0, 200);
        chk("drain_busy", busy, 1);
        chk("drain_layer", layer, 0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_drain");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_drain_idle", busy, 0);

        // Reset while in ERR clears err
        eng_t = '{100000, 100000, 100000};
        clear_q();
        do_start(1);
        wait_err(300);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_err");
        rst = 1'b0;
        eng_t = '{50, 50, 50};
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
